// File: rtl/bsr_meta_walker.sv
// Purpose : walks BSR row_ptr/col_idx metadata BRAMs and emits one descriptor per non-zero 8x8 block.
// Latency : first descriptor 7 cycles after start; 3 cycles/descriptor steady state, +2 per row change or empty row.
// Backpr. : descriptor held stable and all BRAM reads paused while o_desc_valid && !i_desc_ready.
//
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_start, i_num_block_rows    walk request and block-row count (sampled in IDLE only)
//   o_row_ptr_rd_en/_addr, i_row_ptr_data   row_ptr BRAM port (1-cycle read latency)
//   o_col_idx_rd_en/_addr, i_col_idx_data   col_idx BRAM port (1-cycle read latency)
//   o_desc_valid, i_desc_ready, o_desc_*    descriptor stream (valid/ready)
//   o_busy, o_done, o_err        walk status; o_err is sticky until the next accepted start
module bsr_meta_walker #(
    parameter int ROW_W = 16,
    parameter int IDX_W = 32,
    parameter int COL_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_num_block_rows,
    output logic             o_row_ptr_rd_en,
    output logic [ROW_W-1:0] o_row_ptr_addr,
    input  logic [IDX_W-1:0] i_row_ptr_data,
    output logic             o_col_idx_rd_en,
    output logic [15:0]      o_col_idx_addr,
    input  logic [IDX_W-1:0] i_col_idx_data,
    output logic             o_desc_valid,
    input  logic             i_desc_ready,
    output logic [ROW_W-1:0] o_desc_row,
    output logic [IDX_W-1:0] o_desc_blk_idx,
    output logic [COL_W-1:0] o_desc_col,
    output logic             o_desc_last_in_row,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RP0_REQ,
        ST_RP0_WAIT,
        ST_RP_REQ,
        ST_RP_WAIT,
        ST_CI_REQ,
        ST_CI_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [ROW_W-1:0] r_nrows;
    logic [ROW_W-1:0] r_row;
    logic [IDX_W-1:0] r_k;
    logic [IDX_W-1:0] r_blk_start;
    logic [IDX_W-1:0] r_blk_end;
    logic [COL_W-1:0] r_col;
    logic             r_lir;
    logic             r_desc_vld;
    logic             r_rp_rd_en;
    logic [ROW_W-1:0] r_rp_addr;
    logic             r_ci_rd_en;
    logic [15:0]      r_ci_addr;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [ROW_W-1:0] w_row_inc;
    logic [ROW_W-1:0] w_row_inc2;
    logic [IDX_W-1:0] w_k_inc;
    logic             w_last_row;
    logic             w_col_hi_err;
    logic             w_lir;
    logic             w_hs;

    assign w_row_inc    = r_row + ROW_W'(1);
    assign w_row_inc2   = r_row + ROW_W'(2);
    assign w_k_inc      = r_k + IDX_W'(1);
    assign w_last_row   = (r_row == r_nrows - ROW_W'(1));
    assign w_col_hi_err = |i_col_idx_data[IDX_W-1:COL_W];
    // Only evaluated once the row is known non-empty (blk_end > blk_start), so no underflow.
    assign w_lir        = (r_k == r_blk_end - IDX_W'(1));
    assign w_hs         = r_desc_vld && i_desc_ready;

    // Output registers are loaded together with the state they belong to, so a
    // read strobe/address is visible exactly while the FSM sits in the *_REQ state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_nrows     <= '0;
            r_row       <= '0;
            r_k         <= '0;
            r_blk_start <= '0;
            r_blk_end   <= '0;
            r_col       <= '0;
            r_lir       <= 1'b0;
            r_desc_vld  <= 1'b0;
            r_rp_rd_en  <= 1'b0;
            r_rp_addr   <= '0;
            r_ci_rd_en  <= 1'b0;
            r_ci_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rp_rd_en <= 1'b0;
            r_rp_addr  <= '0;
            r_ci_rd_en <= 1'b0;
            r_ci_addr  <= '0;
            r_done     <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_nrows <= i_num_block_rows;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        if (i_num_block_rows == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_RP0_REQ;
                            r_rp_rd_en <= 1'b1;
                        end
                    end
                end

                ST_RP0_REQ: r_state <= ST_RP0_WAIT;

                ST_RP0_WAIT: begin
                    r_blk_start <= i_row_ptr_data;
                    r_state     <= ST_RP_REQ;
                    r_rp_rd_en  <= 1'b1;
                    r_rp_addr   <= w_row_inc;
                end

                ST_RP_REQ: r_state <= ST_RP_WAIT;

                ST_RP_WAIT: begin
                    r_blk_end <= i_row_ptr_data;
                    if (i_row_ptr_data < r_blk_start) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (i_row_ptr_data == r_blk_start) begin
                        // Empty row: blk_start already equals the next row's start.
                        if (w_last_row) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_row      <= w_row_inc;
                            r_state    <= ST_RP_REQ;
                            r_rp_rd_en <= 1'b1;
                            r_rp_addr  <= w_row_inc2;
                        end
                    end else begin
                        r_k        <= r_blk_start;
                        r_state    <= ST_CI_REQ;
                        r_ci_rd_en <= 1'b1;
                        r_ci_addr  <= r_blk_start[15:0];
                    end
                end

                ST_CI_REQ: r_state <= ST_CI_WAIT;

                ST_CI_WAIT: begin
                    r_col <= i_col_idx_data[COL_W-1:0];
                    if (w_col_hi_err) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_lir      <= w_lir;
                        r_desc_vld <= 1'b1;
                        r_state    <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (w_hs) begin
                        r_desc_vld <= 1'b0;
                        if (!r_lir) begin
                            r_k        <= w_k_inc;
                            r_state    <= ST_CI_REQ;
                            r_ci_rd_en <= 1'b1;
                            r_ci_addr  <= w_k_inc[15:0];
                        end else if (w_last_row) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_blk_start <= r_blk_end;
                            r_row       <= w_row_inc;
                            r_state     <= ST_RP_REQ;
                            r_rp_rd_en  <= 1'b1;
                            r_rp_addr   <= w_row_inc2;
                        end
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_row_ptr_rd_en    = r_rp_rd_en;
    assign o_row_ptr_addr     = r_rp_addr;
    assign o_col_idx_rd_en    = r_ci_rd_en;
    assign o_col_idx_addr     = r_ci_addr;
    assign o_desc_valid       = r_desc_vld;
    assign o_desc_row         = r_row;
    assign o_desc_blk_idx     = r_k;
    assign o_desc_col         = r_col;
    assign o_desc_last_in_row = r_lir;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_err              = r_err;

endmodule

// File: tb/tb_bsr_meta_walker.sv
// Purpose : directed bench for bsr_meta_walker with BRAM models and a descriptor scoreboard.
// Latency : cycle numbers counted from the start-sampling edge (first cycle after it is cycle 1).
// Backpr. : i_desc_ready is driven per cycle from the bench; stalls are checked for stable fields.
module tb_bsr_meta_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num;
    logic        rp_en;
    logic [15:0] rp_addr;
    logic [31:0] rp_data = '0;
    logic        ci_en;
    logic [15:0] ci_addr;
    logic [31:0] ci_data = '0;
    logic        vld;
    logic        rdy;
    logic [15:0] row;
    logic [31:0] idx;
    logic [15:0] col;
    logic        lir;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    bsr_meta_walker #(.ROW_W(16), .IDX_W(32), .COL_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_block_rows(num),
        .o_row_ptr_rd_en(rp_en), .o_row_ptr_addr(rp_addr), .i_row_ptr_data(rp_data),
        .o_col_idx_rd_en(ci_en), .o_col_idx_addr(ci_addr), .i_col_idx_data(ci_data),
        .o_desc_valid(vld), .i_desc_ready(rdy), .o_desc_row(row), .o_desc_blk_idx(idx),
        .o_desc_col(col), .o_desc_last_in_row(lir), .o_busy(busy), .o_done(done), .o_err(err)
    );

    // 1-cycle-latency BRAM models
    logic [31:0] rp_mem [0:15];
    logic [31:0] ci_mem [0:15];
    always @(posedge clk) begin
        if (rp_en) rp_data <= rp_mem[rp_addr[3:0]];
        if (ci_en) ci_data <= ci_mem[ci_addr[3:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] row;
        logic [31:0] idx;
        logic [15:0] col;
        logic        lir;
    } desc_t;

    desc_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int s0, cycn;
    int hs_cnt, rp_reads, ci_reads, done_cyc, first_vld, busy_cnt, busy_first;
    bit bp_ok;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [127:0] all_outs();
        return {25'd0, rp_en, rp_addr, ci_en, ci_addr, vld, row, idx, col, lir, busy, done, err};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            rp_mem[i] = '0;
            ci_mem[i] = '0;
        end
    endtask

    task automatic load_nominal();
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 2; rp_mem[3] = 3; rp_mem[4] = 5;
        ci_mem[0] = 7; ci_mem[1] = 1; ci_mem[2] = 4; ci_mem[3] = 0; ci_mem[4] = 9;
    endtask

    task automatic push_exp(input logic [15:0] r, input logic [31:0] k, input logic [15:0] c, input logic l);
        desc_t d;
        d.row = r; d.idx = k; d.col = c; d.lir = l;
        exp_q.push_back(d);
    endtask

    task automatic push_nominal();
        push_exp(0, 0, 7, 0);
        push_exp(0, 1, 1, 1);
        push_exp(2, 2, 4, 1);
        push_exp(3, 3, 0, 0);
        push_exp(3, 4, 9, 1);
    endtask

    // Called once per negedge, after the bench has driven ready for this cycle.
    task automatic sample();
        desc_t got;
        desc_t e;
        if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cycn;
        end
        if (rp_en) rp_reads++;
        if (ci_en) ci_reads++;
        if (vld && first_vld < 0) first_vld = cycn;
        if (done) done_cyc = cycn;
        if (vld && rdy) begin
            got.row = row; got.idx = idx; got.col = col; got.lir = lir;
            hs_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("desc", got, e);
            end else begin
                check("desc_avail", exp_q.size(), 1);
            end
        end
    endtask

    task automatic walk(input logic [15:0] n, input bit bp, input bit pulse);
        hs_cnt = 0; rp_reads = 0; ci_reads = 0; done_cyc = -1; first_vld = -1;
        busy_cnt = 0; busy_first = -1; bp_ok = 1;
        @(negedge clk);
        start = 1'b1;
        num   = n;
        rdy   = 1'b1;
        s0    = cyc + 1;
        for (int i = 0; i < 200 && done_cyc < 0; i++) begin
            @(negedge clk);
            cycn  = cyc - s0 + 1;
            start = pulse && (cycn == 2 || cycn == 8);
            if (start) num = 16'd0;
            rdy = !(bp && cycn >= 10 && cycn <= 14);
            if (bp && cycn >= 10 && cycn <= 14)
                bp_ok &= (vld && row == 0 && idx == 1 && col == 1 && lir && !ci_en && !rp_en);
            sample();
        end
        if (done_cyc < 0) check("walk_done_seen", done_cyc, 0);
        start = 1'b0;
        rdy   = 1'b1;
        @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        bit seen_done, seen_vld;
        rst_n = 1'b0; start = 1'b0; num = '0; rdy = 1'b1;
        clear_mem();
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;

        // Nominal walk
        load_nominal(); push_nominal();
        walk(4, 0, 0);
        check("nom_first_vld", first_vld, 7);
        check("nom_done_cyc", done_cyc, 26);
        check("nom_hs", hs_cnt, 5);
        check("nom_q_empty", exp_q.size(), 0);
        check("nom_err", err, 0);
        check("nom_busy_cnt", busy_cnt, 26);
        check("nom_busy_first", busy_first, 1);
        check("nom_rp_reads", rp_reads, 5);
        check("nom_ci_reads", ci_reads, 5);

        // Backpressure on the second descriptor for 5 cycles
        push_nominal();
        walk(4, 1, 0);
        check("bp_stable", bp_ok, 1);
        check("bp_done_cyc", done_cyc, 31);
        check("bp_hs", hs_cnt, 5);
        check("bp_q_empty", exp_q.size(), 0);

        // start pulsed while busy is ignored
        push_nominal();
        walk(4, 0, 1);
        check("pulse_done_cyc", done_cyc, 26);
        check("pulse_hs", hs_cnt, 5);
        check("pulse_q_empty", exp_q.size(), 0);

        // All rows empty
        clear_mem();
        walk(3, 0, 0);
        check("empty_hs", hs_cnt, 0);
        check("empty_rp_reads", rp_reads, 4);
        check("empty_ci_reads", ci_reads, 0);
        check("empty_done_cyc", done_cyc, 9);

        // Zero rows
        walk(0, 0, 0);
        check("zero_rp_reads", rp_reads, 0);
        check("zero_ci_reads", ci_reads, 0);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_busy_cnt", busy_cnt, 1);
        check("zero_busy_first", busy_first, 1);

        // Decreasing row_ptr
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 3; rp_mem[2] = 1;
        ci_mem[0] = 7; ci_mem[1] = 1; ci_mem[2] = 4;
        push_exp(0, 0, 7, 0); push_exp(0, 1, 1, 0); push_exp(0, 2, 4, 1);
        walk(2, 0, 0);
        check("rperr_hs", hs_cnt, 3);
        check("rperr_q_empty", exp_q.size(), 0);
        check("rperr_err", err, 1);
        check("rperr_rp_reads", rp_reads, 3);
        check("rperr_ci_reads", ci_reads, 3);
        check("rperr_done_cyc", done_cyc, 16);

        // Column index with high bits set
        clear_mem();
        rp_mem[0] = 0; rp_mem[1] = 1;
        ci_mem[0] = 32'h0001_0002;
        walk(1, 0, 0);
        check("cierr_hs", hs_cnt, 0);
        check("cierr_err", err, 1);
        check("cierr_done_cyc", done_cyc, 7);
        check("cierr_ci_reads", ci_reads, 1);

        // Reset during EMIT
        load_nominal();
        @(negedge clk);
        start = 1'b1; num = 16'd4; rdy = 1'b0; s0 = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cycn  = cyc - s0 + 1;
            start = 1'b0;
        end
        check("rst_emit_vld", vld, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", all_outs(), 0);
        rst_n = 1'b1;
        seen_done = 0; seen_vld = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_done |= done;
            seen_vld  |= vld;
        end
        check("rst_no_done", seen_done, 0);
        check("rst_no_vld", seen_vld, 0);
        rdy = 1'b1;

        // Clean walk after reset
        load_nominal(); push_nominal();
        walk(4, 0, 0);
        check("clean_first_vld", first_vld, 7);
        check("clean_done_cyc", done_cyc, 26);
        check("clean_hs", hs_cnt, 5);
        check("clean_q_empty", exp_q.size(), 0);
        check("clean_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
